pc_select_unit: RTL and testbench

//  Fetch-stage PC selection for the Y86-64 five-stage pipeline. Owns the F pipeline register
//  (predicted PC). Combinationally picks the fetch address f_PC from:
//  - the mispredicted-branch fall-through (M stage)
//  - the return address (W stage)
//  - the registered prediction

---
 rtl/y86_pkg.sv | 26 ++
 rtl/pc_select_unit_if.sv | 26 ++
 rtl/pc_mux.sv | 31 +++
 rtl/pc_select_unit.sv | 56 +++++
 tb/tb_pc_select_unit.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode constants, default address width and the
// fetch-PC source encoding.
package y86_pkg;

    localparam int Y86_ADDR_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        SEL_PRED    = 2'd0,
        SEL_MISPRED = 2'd1,
        SEL_RET     = 2'd2
    } f_sel_e;

endpackage

// File: rtl/pc_select_unit_if.sv
// Fetch PC-select bundle: pipeline-side inputs plus the selected fetch address.
interface pc_select_unit_if #(
    parameter int ADDR_W = 64
);
    logic              F_stall;
    logic [ADDR_W-1:0] f_predPC;
    logic [3:0]        M_icode;
    logic              M_cnd;
    logic [ADDR_W-1:0] M_valA;
    logic [3:0]        W_icode;
    logic [ADDR_W-1:0] W_valM;
    logic [ADDR_W-1:0] F_predPC;
    logic [ADDR_W-1:0] f_PC;
    logic [1:0]        f_sel;
    logic              f_imem_er;

    modport master (
        output F_stall, f_predPC, M_icode, M_cnd, M_valA, W_icode, W_valM,
        input  F_predPC, f_PC, f_sel, f_imem_er
    );

    modport slave (
        input  F_stall, f_predPC, M_icode, M_cnd, M_valA, W_icode, W_valM,
        output F_predPC, f_PC, f_sel, f_imem_er
    );
endinterface

// File: rtl/pc_mux.sv
// Priority mux for the fetch address: M-stage mispredict recovery beats
// W-stage ret, which beats the registered prediction.
module pc_mux
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [3:0]        m_icode,
    input  logic              m_cnd,
    input  logic [ADDR_W-1:0] m_val_a,
    input  logic [3:0]        w_icode,
    input  logic [ADDR_W-1:0] w_val_m,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic [ADDR_W-1:0] f_pc,
    output f_sel_e            f_sel
);

    always_comb begin
        f_pc  = pred_pc;
        f_sel = SEL_PRED;
        // The M instruction is younger than W, so its recovery wins on overlap
        if (m_icode == IJXX && !m_cnd) begin
            f_pc  = m_val_a;
            f_sel = SEL_MISPRED;
        end else if (w_icode == IRET) begin
            f_pc  = w_val_m;
            f_sel = SEL_RET;
        end
    end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch-stage PC selection: owns the F predicted-PC register, picks f_PC and
// flags fetches outside instruction memory.
module pc_select_unit
    import y86_pkg::*;
#(
    parameter int                ADDR_W     = Y86_ADDR_W,
    parameter int                IMEM_BYTES = 2048,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_select_unit_if.slave  bus
);

    localparam logic [ADDR_W-1:0] IMEM_LIM = ADDR_W'(IMEM_BYTES);

    logic [ADDR_W-1:0] pred_pc_d, pred_pc_q;
    logic [ADDR_W-1:0] mux_pc, f_pc;
    f_sel_e            mux_sel, f_sel;

    always_comb begin
        pred_pc_d = bus.F_stall ? pred_pc_q : bus.f_predPC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pred_pc_q <= RESET_PC;
        else        pred_pc_q <= pred_pc_d;
    end

    pc_mux #(.ADDR_W(ADDR_W)) u_pc_mux (
        .m_icode (bus.M_icode),
        .m_cnd   (bus.M_cnd),
        .m_val_a (bus.M_valA),
        .w_icode (bus.W_icode),
        .w_val_m (bus.W_valM),
        .pred_pc (pred_pc_q),
        .f_pc    (mux_pc),
        .f_sel   (mux_sel)
    );

    // During reset M/W may hold stale state; never let it steer the fetch
    always_comb begin
        f_pc  = mux_pc;
        f_sel = mux_sel;
        if (!rst_n) begin
            f_pc  = RESET_PC;
            f_sel = SEL_PRED;
        end
    end

    assign bus.F_predPC  = pred_pc_q;
    assign bus.f_PC      = f_pc;
    assign bus.f_sel     = f_sel;
    assign bus.f_imem_er = (f_pc >= IMEM_LIM);

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed and randomized checks of pc_select_unit against a behavioural model.
module tb_pc_select_unit;

    localparam int          ADDR_W = 64;
    localparam logic [63:0] IMEM   = 64'd2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_select_unit_if #(.ADDR_W(ADDR_W)) bus ();

    pc_select_unit #(.ADDR_W(ADDR_W), .IMEM_BYTES(2048), .RESET_PC('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic [63:0] pred,
                         input logic [3:0] mi, input logic mc, input logic [63:0] mva,
                         input logic [3:0] wi, input logic [63:0] wvm);
        bus.F_stall  = stall;
        bus.f_predPC = pred;
        bus.M_icode  = mi;
        bus.M_cnd    = mc;
        bus.M_valA   = mva;
        bus.W_icode  = wi;
        bus.W_valM   = wvm;
    endtask

    // Reference: what the fetch stage should fetch given the pipeline state
    logic [63:0] model_pred;
    logic [63:0] exp_pc;
    logic [1:0]  exp_sel;

    task automatic model_eval();
        if (!rst_n) begin
            exp_pc = 64'd0; exp_sel = 2'd0;
        end else if (bus.M_icode == 4'd7 && bus.M_cnd == 1'b0) begin
            exp_pc = bus.M_valA; exp_sel = 2'd1;
        end else if (bus.W_icode == 4'd9) begin
            exp_pc = bus.W_valM; exp_sel = 2'd2;
        end else begin
            exp_pc = model_pred; exp_sel = 2'd0;
        end
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 3))
            0: a = {$urandom, $urandom};
            1: a = 64'd2048 - 64'($urandom_range(0, 2));
            default: a = 64'($urandom_range(0, 4095));
        endcase
        return a;
    endfunction

    function automatic logic [3:0] rand_icode();
        logic [3:0] i;
        case ($urandom_range(0, 3))
            0: i = 4'd7;
            1: i = 4'd9;
            default: i = 4'($urandom_range(0, 15));
        endcase
        return i;
    endfunction

    initial begin
        drive(1'b0, 64'h0, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        #2;
        chk("reset_predpc", bus.F_predPC, 64'h0);
        chk("reset_fpc", bus.f_PC, 64'h0);
        chk("reset_fsel", {62'd0, bus.f_sel}, 64'd0);

        // Load 0x40, then reset asynchronously while M requests a redirect
        @(negedge clk); rst_n = 1'b1;
        drive(1'b0, 64'h40, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        @(negedge clk);
        chk("load_40", bus.F_predPC, 64'h40);
        #2;
        drive(1'b0, 64'h40, 4'h7, 1'b0, 64'h1F, 4'h9, 64'h88);
        rst_n = 1'b0;
        #1;
        chk("async_rst_predpc", bus.F_predPC, 64'h0);
        chk("async_rst_fpc", bus.f_PC, 64'h0);
        chk("async_rst_fsel", {62'd0, bus.f_sel}, 64'd0);
        chk("async_rst_er", {63'd0, bus.f_imem_er}, 64'd0);
        drive(1'b0, 64'h0A, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        #2;
        chk("first_after_rst", bus.f_PC, 64'h0);

        @(negedge clk);
        chk("advance_predpc", bus.F_predPC, 64'h0A);
        chk("advance_fpc", bus.f_PC, 64'h0A);

        drive(1'b1, 64'h14, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        repeat (3) @(negedge clk);
        chk("stall_hold", bus.F_predPC, 64'h0A);

        drive(1'b1, 64'h14, 4'h7, 1'b0, 64'h1F, 4'h1, 64'h0);
        #2;
        chk("mispred_fpc", bus.f_PC, 64'h1F);
        chk("mispred_fsel", {62'd0, bus.f_sel}, 64'd1);
        bus.M_cnd = 1'b1;
        #1;
        chk("taken_fpc", bus.f_PC, 64'h0A);
        chk("taken_fsel", {62'd0, bus.f_sel}, 64'd0);

        drive(1'b1, 64'h14, 4'h1, 1'b0, 64'h1F, 4'h9, 64'h88);
        #1;
        chk("ret_fpc", bus.f_PC, 64'h88);
        chk("ret_fsel", {62'd0, bus.f_sel}, 64'd2);
        bus.M_icode = 4'h7;
        #1;
        chk("both_fpc", bus.f_PC, 64'h1F);
        chk("both_fsel", {62'd0, bus.f_sel}, 64'd1);

        @(negedge clk);
        drive(1'b0, 64'h7FF, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        @(negedge clk);
        chk("range_7ff", {63'd0, bus.f_imem_er}, 64'd0);
        drive(1'b0, 64'h800, 4'h1, 1'b0, 64'h0, 4'h1, 64'h0);
        @(negedge clk);
        chk("range_800", {63'd0, bus.f_imem_er}, 64'd1);

        // Randomized phase: inputs change on negedge, checked mid-low phase
        model_pred = 64'h800;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 19) != 0);
            drive(1'($urandom_range(0, 3) == 0), rand_addr(), rand_icode(),
                  1'($urandom_range(0, 1)), rand_addr(), rand_icode(), rand_addr());
            if (!rst_n) model_pred = 64'd0;
            #2;
            model_eval();
            chk("rnd_fpc", bus.f_PC, exp_pc);
            chk("rnd_fsel", {62'd0, bus.f_sel}, {62'd0, exp_sel});
            chk("rnd_er", {63'd0, bus.f_imem_er}, {63'd0, exp_pc >= IMEM});
            chk("rnd_predpc", bus.F_predPC, model_pred);
            @(posedge clk);
            if (rst_n && !bus.F_stall) model_pred = bus.f_predPC;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
